count_sequence_monitor: RTL
===========================

Name: count_sequence_monitor

Overview:
- Receiving end of the lab counter outputs. Samples a 4-bit counter bus, such as the LEDR[3:0] value driven by any of the four down counters, in the fast clock domain.
- Filters ripple transients and checks each settled step against the expected down-count sequence.
- Reports lock, per-step errors and a saturating error count.
- Sits beside the counter under test as a self-check for bring-up and verification.

Parameters:
- SYNC_STAGES, 2, flops in the input synchronizer chain on count_in (minimum 2)
- STABLE_CYCLES, 4, consecutive identical synchronized samples needed before a value is accepted (minimum 1)
- LOCK_STEPS, 3, consecutive correct transitions needed before locked asserts

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- count_in  in  4  counter value under observation; asynchronous to the counter's divided clock
- mode  in  1  0 = 4-bit binary down, 1 = 4-bit Johnson down
- step  out  1  one-cycle pulse when a new settled value is accepted
- value  out  4  last accepted value
- locked  out  1  sequence tracking confirmed
- err  out  1  one-cycle pulse on a wrong or illegal step
- err_count  out  8  errors since reset, saturates at 255

Behaviour:
- Reset values: step=0, value=0, locked=0, err=0, err_count=0. The synchronizer chain, stability filter and FSM all clear; the FSM returns to IDLE.
- Synchronizer: count_in passes through SYNC_STAGES flops, giving the sample s.
- Stability filter: holds a candidate and a run counter.
  - If s equals the candidate, the run counter increments, saturating.
  - Otherwise the candidate becomes s and the run counter goes to 1.
  - When the run reaches STABLE_CYCLES and the candidate differs from value, the block accepts it: value updates and step pulses, both in the same cycle.
  - Latency from a count_in change to step is SYNC_STAGES+STABLE_CYCLES cycles.
  - A re-settle on the already accepted value produces no step.
- Expected next value:
  - Binary down: value-1 mod 16, so 0 wraps to 15.
  - Johnson down: {~v[0], v[3:1]}, giving 0000→1000→1100→1110→1111→0111→0011→0001→0000.
  - Johnson legal codes are those 8 only; any other code is illegal.
- FSM states: IDLE, ACQUIRE, TRACK.
  - IDLE: the first accepted value becomes the base.
    - If legal for the mode, go to ACQUIRE with good-step count 0.
    - If illegal (Johnson only), err pulses and the FSM stays in IDLE.
  - ACQUIRE and TRACK, on each step:
    - New value equals expected: the good-step count increments. When it reaches LOCK_STEPS in ACQUIRE, go to TRACK and set locked=1; the assertion takes effect in the cycle after the qualifying step.
    - Mismatch or illegal code: err pulses and locked clears, both in the cycle after the step. err_count increments (saturating). The new value becomes the base if legal; otherwise go to IDLE. The FSM enters ACQUIRE and the good-step count resets to 0.
- Mode change: detected by comparing against a registered copy of mode. The FSM goes to IDLE and locked clears on the next cycle. err_count is kept; no err pulse is produced.
- Simultaneous mode change and step: the mode change wins and the step is ignored for checking, but value still updates.
- rst mid-operation: clears everything on the next edge regardless of state.

Optional Feature:
- Macro: MONITOR_STICKY_FAULT_EN.
- Defined: adds a FAULT state.
  - The first error moves the FSM to FAULT. err pulses once, locked=0 and err_count=1.
  - In FAULT, further steps still update value and step, but produce no err and no count increment.
  - Only rst leaves FAULT. A mode change does not leave FAULT.
- Undefined: resynchronizing behaviour as described in Behaviour; no FAULT state exists.

Decomposition:
- Package monitor_pkg holds:
  - mode encodings MODE_BIN_DOWN=0 and MODE_JOHNSON_DOWN=1
  - FSM state enum (IDLE, ACQUIRE, TRACK, FAULT)
  - function next_down(value, mode)
  - function is_legal(value, mode)
  - ERR_COUNT_MAX=255
- Sub-module count_debounce: the synchronizer plus stability filter, with outputs value and step. The parent owns the FSM and the counters.

Test Plan:
- Binary down, defaults, mode=0. Drive 5,4,3,2 with each value held 20 cycles → step on each change 6 cycles after it; locked=1 the cycle after the step for 2; err never asserts.
- Binary wrap-around. Lock on 2,1,0, then drive 15 → no err; value=15; locked stays 1.
- Johnson down, mode=1. Drive 0000,1000,1100,1110 → locked=1. Then drive 0101 → err pulse, err_count=1, locked=0, FSM in IDLE. Then drive 0011,0001,0000,1000 → relocks.
- Glitch rejection. While value=7, pulse count_in to 3 for 2 cycles and return to 7 → no step, no err. Then step to 6 → step pulse, no err.
- Error saturation. Drive 300 wrong steps in binary mode, alternating 9 and 4 → err_count stops at 255.
- With MONITOR_STICKY_FAULT_EN defined: lock, skip a value (8→6) → err once, err_count=1. Later wrong steps give no err, and toggling mode stays in FAULT. Assert rst for 1 cycle → all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for count_sequence_monitor: mode encodings, FSM states,
// expected-next-value and legality helpers for the two down-count sequences.
// Optional feature macro used by the monitor: MONITOR_STICKY_FAULT_EN.
package monitor_pkg;

  localparam logic       MODE_BIN_DOWN     = 1'b0;
  localparam logic       MODE_JOHNSON_DOWN = 1'b1;
  localparam logic [7:0] ERR_COUNT_MAX     = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    FAULT   = 2'd3
  } state_e;

  // Value the counter should show after one down step from 'value'.
  function automatic logic [3:0] next_down(input logic [3:0] value, input logic mode);
    logic [3:0] nxt;
    if (mode == MODE_JOHNSON_DOWN) begin
      nxt = {~value[0], value[3:1]};
    end else begin
      nxt = value - 4'd1;
    end
    return nxt;
  endfunction

  // Binary accepts every code; Johnson accepts only its 8 ring codes.
  function automatic logic is_legal(input logic [3:0] value, input logic mode);
    logic ok;
    if (mode == MODE_JOHNSON_DOWN) begin
      case (value)
        4'b0000, 4'b1000, 4'b1100, 4'b1110,
        4'b1111, 4'b0111, 4'b0011, 4'b0001: ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/count_debounce.sv
// Input synchronizer plus stability filter for the observed counter bus.
// A value is accepted once STABLE_CYCLES identical synchronized samples have
// been seen and it differs from the last accepted value; step pulses then.
module count_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  output logic [3:0] value,
  output logic       step
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]       sample_s;
  logic [3:0]       cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0]       value_q, value_d;
  logic             step_q, step_d;

  assign sample_s = sync_q[SYNC_STAGES-1];
  assign value    = value_q;
  assign step     = step_q;

  // Shift the raw bus through the synchronizer chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = count_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Track the run length of the current candidate and accept settled values.
  always_comb begin
    cand_d  = cand_q;
    run_d   = run_q;
    value_d = value_q;
    step_d  = 1'b0;
    if (sample_s == cand_q) begin
      if (run_q == RUN_MAX) begin
        run_d = run_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      cand_d = sample_s;
      run_d  = RUN_W'(1);
    end
    if ((run_d == RUN_MAX) && (cand_d != value_q)) begin
      value_d = cand_d;
      step_d  = 1'b1;
    end else begin
      step_d  = 1'b0;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cand_q  <= 4'd0;
      run_q   <= RUN_W'(0);
      value_q <= 4'd0;
      step_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks settled counter values against the expected down-count sequence,
// reporting lock, per-step error pulses and a saturating error count.
// Define MONITOR_STICKY_FAULT_EN to latch the first error in a FAULT state
// that only reset leaves; by default the monitor resynchronizes after errors.
module count_sequence_monitor
  import monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_STEPS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  input  logic       mode,
  output logic       step,
  output logic [3:0] value,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_STEPS + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_STEPS);

  logic              deb_step;
  logic [3:0]        deb_value;
  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [3:0]        base_q, base_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              mode_chg_s;
  logic              legal_s;
  logic [3:0]        expected_s;
  logic [GOOD_W-1:0] good_inc_s;

  count_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .count_in(count_in),
    .value   (deb_value),
    .step    (deb_step)
  );

  assign step       = deb_step;
  assign value      = deb_value;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

  // Checking always uses the registered mode, so a mode edge is seen for one cycle.
  assign mode_chg_s = (mode != mode_q);
  assign legal_s    = is_legal(deb_value, mode_q);
  assign expected_s = next_down(base_q, mode_q);
  assign good_inc_s = good_q + GOOD_W'(1);

  // Sequence-tracking FSM: next state, lock flag, error pulse and error count.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode;
    base_d      = base_q;
    good_d      = good_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (mode_chg_s) begin
      // A mode edge restarts acquisition; any coincident step is not checked.
      state_d  = IDLE;
      good_d   = GOOD_W'(0);
      locked_d = 1'b0;
    end else if (deb_step) begin
      case (state_q)
        IDLE: begin
          if (legal_s) begin
            state_d = ACQUIRE;
            base_d  = deb_value;
            good_d  = GOOD_W'(0);
          end else begin
            err_d   = 1'b1;
          end
        end
        ACQUIRE, TRACK: begin
          if (deb_value == expected_s) begin
            base_d = deb_value;
            if (state_q == ACQUIRE) begin
              good_d = good_inc_s;
              if (good_inc_s == GOOD_LOCK) begin
                state_d  = TRACK;
                locked_d = 1'b1;
              end else begin
                state_d  = ACQUIRE;
              end
            end else begin
              good_d = good_q;
            end
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = GOOD_W'(0);
            if (legal_s) begin
              base_d  = deb_value;
              state_d = ACQUIRE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          good_d   = GOOD_W'(0);
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

`ifdef MONITOR_STICKY_FAULT_EN
    // FAULT swallows all further activity, including mode changes.
    if (state_q == FAULT) begin
      state_d  = FAULT;
      base_d   = base_q;
      good_d   = GOOD_W'(0);
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (err_d) begin
      state_d  = FAULT;
      locked_d = 1'b0;
    end else begin
      state_d  = state_d;
    end
`endif

    if (err_d && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      base_q      <= 4'd0;
      good_q      <= GOOD_W'(0);
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
